register_file: RTL and testbench
================================

Name: register_file

Overview:
- General-purpose integer register file for the RISC processor datapath.
- 32 architectural registers, 32 bits each, with register x0 hardwired to zero.
- Two combinational read ports feed the decode/execute operands (rs1, rs2); one synchronous write port takes the writeback result (rd).
- Synchronous active-high reset clears the whole array.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH (32 entries).
- WRITE_BYPASS, 0, when 1 a read port addressing the register being written in the current cycle returns rd_data combinationally; when 0 it returns the stored (old) value until the edge.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers on the rising edge while high.
- reg_write  input  1  write enable for the rd port.
- rs1_addr  input  ADDR_WIDTH  read port 1 address.
- rs2_addr  input  ADDR_WIDTH  read port 2 address.
- rd_addr  input  ADDR_WIDTH  write port address.
- rd_data  input  DATA_WIDTH  write data.
- rs1_data  output  DATA_WIDTH  read port 1 data, combinational.
- rs2_data  output  DATA_WIDTH  read port 2 data, combinational.

Behaviour:
- Storage: 2**ADDR_WIDTH entries of DATA_WIDTH bits. No initial-value reliance; contents are defined only after reset.
- Reset: on a rising clk edge with reset=1, every entry becomes 0. reset has priority over reg_write in the same cycle, so no write occurs. Both outputs then read 0 for any address.
- Write: on a rising clk edge with reset=0, reg_write=1 and rd_addr!=0, entry[rd_addr] <= rd_data. Write latency is one edge.
- x0: writes to address 0 are ignored. rs*_data for address 0 is always 0, forced at the read mux regardless of array contents.
- Read: rs1_data = entry[rs1_addr], rs2_data = entry[rs2_addr]. Reads are purely combinational with zero-cycle latency. After a write edge, the new value is visible on any port addressing that register in the same delta and all later cycles.
- Ports are independent: both read ports may address the same register, or the register being written.
- Same-cycle read-during-write, WRITE_BYPASS=0: the read returns the old value before the edge and the new value after it.
- Same-cycle read-during-write, WRITE_BYPASS=1: when reg_write=1, reset=0, rd_addr!=0 and rsN_addr==rd_addr, rsN_data = rd_data before the edge. The x0 rule still overrides the bypass.
- reg_write=0: the array is unchanged regardless of rd_addr/rd_data.
- Reset mid-operation: a pending write in a reset cycle is discarded. Values written before reset are lost.
- No X propagation on outputs after reset for any address.

Test Plan:
- Reset: assert reset for one edge, deassert, all addresses 0 -> rs1_data=00000000, rs2_data=00000000.
- Write/read x1: reg_write=1, rd_addr=1, rd_data=12345678, one edge; then reg_write=0, rs1_addr=1 -> rs1_data=12345678.
- x0 protection: reg_write=1, rd_addr=0, rd_data=FFFFFFFF, one edge; rs1_addr=0 -> rs1_data=00000000.
- Dual read: write x2=87654321 (x1 holds 12345678); rs1_addr=1, rs2_addr=2 -> rs1_data=12345678, rs2_data=87654321. Also set both ports to 2 -> both read 87654321.
- Reset priority and mid-operation: with x1=12345678, assert reset and reg_write=1, rd_addr=3, rd_data=DEADBEEF on the same edge -> x1=0, x3=0 afterwards.
- Read-during-write:
  - Setup: x4=11111111.
  - Stimulus: reg_write=1, rd_addr=4, rd_data=22222222, rs1_addr=4, sampled before the edge.
  - WRITE_BYPASS=0 -> 11111111 before the edge, 22222222 after.
  - WRITE_BYPASS=1 -> 22222222 before the edge.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32 x 32-bit integer register file with x0 hardwired to zero.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every entry (wins over reg_write)
//   reg_write  write enable for the rd port
//   rs1_addr   read port 1 address
//   rs2_addr   read port 2 address
//   rd_addr    write port address (writes to 0 are dropped)
//   rd_data    write data
//   rs1_data   read port 1 data, combinational
//   rs2_data   read port 2 data, combinational
//
// WRITE_BYPASS=1 forwards rd_data to a read port addressing the register
// being written this cycle; WRITE_BYPASS=0 shows the stored value until the edge.

// One combinational read port: array mux, optional write forwarding, x0 force.
module register_file_rd_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int WRITE_BYPASS = 0
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  input  logic                                       wr_en,
  input  logic [ADDR_WIDTH-1:0]                      wr_addr,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic [DATA_WIDTH-1:0]                      data
);
  always_comb begin
    data = regs[addr];
    if ((WRITE_BYPASS != 0) && wr_en && (addr == wr_addr))
      data = wr_data;
    // x0 is forced last so neither array contents nor the bypass can leak through
    if (addr == '0)
      data = '0;
  end
endmodule

module register_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int WRITE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs;
  logic                              wr_en;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_port_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_port_data;

  // Effective write: reset discards it, x0 is never a target.
  assign wr_en = reg_write && !reset && (rd_addr != '0);

  always_ff @(posedge clk) begin
    if (reset)
      regs <= '0;
    else if (wr_en)
      regs[rd_addr] <= rd_data;
  end

  assign rd_port_addr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    register_file_rd_port #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WRITE_BYPASS(WRITE_BYPASS)
    ) u_rd (
      .regs   (regs),
      .addr   (rd_port_addr[p]),
      .wr_en  (wr_en),
      .wr_addr(rd_addr),
      .wr_data(rd_data),
      .data   (rd_port_data[p])
    );
  end

  assign rs1_data = rd_port_data[0];
  assign rs2_data = rd_port_data[1];
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one instance without and one with write bypass share
// the same stimulus. Expected values are queued as stimulus is applied and
// popped/compared once the combinational outputs have settled.
module tb_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rs1_nb, rs2_nb, rs1_bp, rs2_bp;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_data(rs1_nb), .rs2_data(rs2_nb));

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_data(rs1_bp), .rs2_data(rs2_bp));

  // sel: 0 = no-bypass rs1, 1 = no-bypass rs2, 2 = bypass rs1, 3 = bypass rs2
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs;
  logic [31:0] mdl [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return rs1_nb;
      1:       return rs2_nb;
      2:       return rs1_bp;
      default: return rs2_bp;
    endcase
  endfunction

  function automatic void push(input string name, input int sel, input logic [31:0] exp);
    exp_t x;
    x.name = name; x.sel = sel; x.exp = exp;
    sb.push_back(x);
  endfunction

  // Advance past the next rising edge; inputs change and outputs are sampled
  // mid-cycle, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write = 1'b1; rd_addr = a; rd_data = d;
    step();
    if (a != 5'd0) mdl[a] = d;
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      for (int s = 0; s < 4; s++) push("reset_clear", s, 32'h0);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = observe(e.sel); n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s addr%0d sel%0d: got %h expected %h", e.name, i, e.sel, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_write_read();
    wr(5'd1, 32'h12345678);
    rs1_addr = 5'd1; rs2_addr = 5'd1;
    for (int s = 0; s < 4; s++) push("write_read_x1", s, 32'h12345678);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
  endtask

  task automatic test_x0();
    // During the write cycle the bypass must not expose rd_data on x0.
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    for (int s = 0; s < 4; s++) push("x0_pre_edge", s, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
    step();
    reg_write = 1'b0;
    for (int s = 0; s < 4; s++) push("x0_post_edge", s, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
  endtask

  task automatic test_dual_read();
    wr(5'd2, 32'h87654321);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    push("dual_rs1", 0, 32'h12345678); push("dual_rs2", 1, 32'h87654321);
    push("dual_rs1", 2, 32'h12345678); push("dual_rs2", 3, 32'h87654321);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
    rs1_addr = 5'd2; rs2_addr = 5'd2;
    for (int s = 0; s < 4; s++) push("dual_same", s, 32'h87654321);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
  endtask

  task automatic test_write_disable();
    // reg_write=0: no change, and no bypass either.
    reg_write = 1'b0; rd_addr = 5'd1; rd_data = 32'hAAAA5555;
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    push("wdis_pre", 2, 32'h12345678); push("wdis_pre", 0, 32'h12345678);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
    step();
    push("wdis_post", 0, 32'h12345678); push("wdis_post", 2, 32'h12345678);
    push("wdis_post", 1, 32'h87654321); push("wdis_post", 3, 32'h87654321);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    // Bypass is gated by reset, so the bypass instance still shows stored x3 (0).
    reset = 1'b1; reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'hDEADBEEF;
    rs1_addr = 5'd1; rs2_addr = 5'd3;
    push("rstpri_pre_x1", 2, 32'h12345678); push("rstpri_pre_x3", 3, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
    step();
    reset = 1'b0; reg_write = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int s = 0; s < 4; s++) push("rstpri_post", s, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    wr(5'd4, 32'h11111111);
    reg_write = 1'b1; rd_addr = 5'd4; rd_data = 32'h22222222;
    rs1_addr = 5'd4; rs2_addr = 5'd5;
    push("rdw_pre_nb", 0, 32'h11111111); push("rdw_pre_bp", 2, 32'h22222222);
    push("rdw_pre_other", 1, 32'h0);     push("rdw_pre_other", 3, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
    step();
    mdl[4] = 32'h22222222;
    reg_write = 1'b0; rs2_addr = 5'd4;
    for (int s = 0; s < 4; s++) push("rdw_post", s, 32'h22222222);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.sel); n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 1; i < 32; i++) begin
      d = $urandom;
      reg_write = 1'b1; rd_addr = 5'(i); rd_data = d;
      rs1_addr = 5'(i); rs2_addr = 5'(i - 1);
      // Before the edge: stored vs forwarded value of the target, previous register intact.
      push("b2b_pre_nb", 0, mdl[i]); push("b2b_pre_bp", 2, d);
      push("b2b_prev", 1, mdl[i-1]);  push("b2b_prev", 3, mdl[i-1]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = observe(e.sel); n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s x%0d sel%0d: got %h expected %h", e.name, i, e.sel, obs, e.exp);
        end
      end
      step();
      mdl[i] = d;
    end
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      push("b2b_final", 0, mdl[i]);      push("b2b_final", 2, mdl[i]);
      push("b2b_final", 1, mdl[31 - i]); push("b2b_final", 3, mdl[31 - i]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = observe(e.sel); n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s idx%0d sel%0d: got %h expected %h", e.name, i, e.sel, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    #2;
    test_reset();
    test_write_read();
    test_x0();
    test_dual_read();
    test_write_disable();
    test_reset_priority();
    test_read_during_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
